// File: rtl/sl_pkg.sv
`timescale 1ns/1ps
// sl_pkg: shared types and constants for the SL word receiver.
//   - FSM state encoding
//   - configuration register field positions and reset value
//   - word length / timeout limits and the timeout-limit helper
package sl_pkg;

    typedef enum logic [1:0] {
        StIdle,  // no word open
        StGap,   // word open, both lines high between symbols
        StSym,   // first low sample seen, classify on the next one
        StRel    // symbol taken, waiting for both lines to return high
    } sl_state_e;

    // Configuration register layout.
    localparam int unsigned CFG_W        = 10;
    localparam int unsigned CFG_LEN_LSB  = 0;
    localparam int unsigned CFG_LEN_MSB  = 5;
    localparam int unsigned CFG_MODE_LSB = 6;
    localparam int unsigned CFG_MODE_MSB = 8;
    localparam int unsigned CFG_RSVD_BIT = 9;

    localparam int unsigned LEN_W  = CFG_LEN_MSB - CFG_LEN_LSB + 1;
    localparam int unsigned MODE_W = CFG_MODE_MSB - CFG_MODE_LSB + 1;

    // Stored config excludes the reserved bit; reset is length 8, mode 0.
    localparam logic [CFG_W-2:0] CFG_RST = 9'b000_001000;

    localparam int unsigned MAX_BITS     = 33;
    localparam int unsigned DATA_W       = 32;
    localparam int unsigned CNT_W        = 6;
    localparam int unsigned TIMEOUT_BASE = 16;
    localparam int unsigned MAX_MODE     = 5;
    localparam int unsigned TMO_W        = 10;  // wide enough for 16 << 5

    localparam logic [1:0] PAIR_IDLE = 2'b11;
    localparam logic [1:0] PAIR_ONE  = 2'b01;
    localparam logic [1:0] PAIR_ZERO = 2'b10;
    localparam logic [1:0] PAIR_STOP = 2'b00;

    // Timeout limit in clocks for a mode value; modes above MAX_MODE clamp.
    function automatic logic [TMO_W-1:0] timeout_limit(input logic [MODE_W-1:0] mode);
        logic [MODE_W-1:0] m;
        m = (mode > MODE_W'(MAX_MODE)) ? MODE_W'(MAX_MODE) : mode;
        return TMO_W'(TIMEOUT_BASE) << m;
    endfunction

endpackage

// File: rtl/sl_word_receiver_if.sv
`timescale 1ns/1ps
// sl_word_receiver_if: line, configuration and result signals of the receiver.
//   slave  : receiver side (lines/config in, results out)
//   master : driving side (lines/config out, results in)
interface sl_word_receiver_if;
    import sl_pkg::*;

    logic                sl0;
    logic                sl1;
    logic                cfg_wr_en;
    logic [CFG_W-1:0]    cfg_wr_data;
    logic [CFG_W-1:0]    cfg_rd;
    logic [DATA_W-1:0]   data_out;
    logic [CNT_W-1:0]    bit_count;
    logic                data_valid;
    logic                parity_err;
    logic                len_err;
    logic                timeout_err;
    logic                busy;
    logic                status_changed;

    modport slave (
        input  sl0, sl1, cfg_wr_en, cfg_wr_data,
        output cfg_rd, data_out, bit_count, data_valid, parity_err, len_err,
               timeout_err, busy, status_changed
    );

    modport master (
        output sl0, sl1, cfg_wr_en, cfg_wr_data,
        input  cfg_rd, data_out, bit_count, data_valid, parity_err, len_err,
               timeout_err, busy, status_changed
    );

endinterface

// File: rtl/sl_line_sync.sv
`timescale 1ns/1ps
// sl_line_sync: two-flop synchronizer for one asynchronous SL line.
//   clk    : system clock
//   rst    : synchronous active-high reset, output resets to idle-high
//   line_i : raw asynchronous line
//   line_o : synchronized line
module sl_line_sync (
    input  logic clk,
    input  logic rst,
    input  logic line_i,
    output logic line_o
);

    logic [1:0] sync_q, sync_d;

    always_comb begin
        sync_d = {sync_q[0], line_i};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign line_o = sync_q[1];

endmodule

// File: rtl/sl_word_receiver.sv
`timescale 1ns/1ps
// sl_word_receiver: decodes words sent over the two-wire SL link.
//   clk : system clock, rst : synchronous active-high reset
//   bus : sl0/sl1 lines and config write in; config readback, received word,
//         bit count, data_valid/parity_err/len_err/timeout_err, busy and
//         status_changed out.
// A bit is one line pulled low (sl0 -> 0, sl1 -> 1), stop is both low. The last
// bit before stop is odd parity. Words are MSB first, up to 32 data bits.
module sl_word_receiver
    import sl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    sl_word_receiver_if.slave bus
);

    logic       s0, s1;
    logic [1:0] pair;

    sl_line_sync u_sync0 (.clk(clk), .rst(rst), .line_i(bus.sl0), .line_o(s0));
    sl_line_sync u_sync1 (.clk(clk), .rst(rst), .line_i(bus.sl1), .line_o(s1));

    assign pair = {s1, s0};

    sl_state_e           state_q, state_d;
    logic                from_gap_q, from_gap_d;  // where a glitch returns to
    logic                stop_q, stop_d;          // REL entered from a stop
    logic                ovf_q, ovf_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [MAX_BITS-1:0] sh_q, sh_d;
    logic [LEN_W-1:0]    len_snap_q, len_snap_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic [1:0]          pair_q, pair_d;
    logic [CFG_W-2:0]    cfg_q, cfg_d;
    logic [DATA_W-1:0]   data_out_q, data_out_d;
    logic [CNT_W-1:0]    bit_count_q, bit_count_d;
    logic                parity_err_q, parity_err_d;
    logic                len_err_q, len_err_d;
    logic                data_valid_q, data_valid_d;
    logic                timeout_err_q, timeout_err_d;
    logic                status_changed_q, status_changed_d;

    logic                pair_changed;
    logic                do_stop;
    logic [CNT_W-1:0]    stop_count;
    logic [TMO_W-1:0]    tmo_limit;
    logic                unused_rsvd;

    assign unused_rsvd = bus.cfg_wr_data[CFG_RSVD_BIT];
    assign tmo_limit   = timeout_limit(cfg_q[CFG_MODE_MSB:CFG_MODE_LSB]);
    // Data bits exclude the parity bit; an empty word reports zero.
    assign stop_count  = (cnt_q == '0) ? '0 : cnt_q - CNT_W'(1);

    always_comb begin
        state_d          = state_q;
        from_gap_d       = from_gap_q;
        stop_d           = stop_q;
        ovf_d            = ovf_q;
        cnt_d            = cnt_q;
        sh_d             = sh_q;
        len_snap_d       = len_snap_q;
        tmo_d            = tmo_q;
        pair_d           = pair;
        cfg_d            = cfg_q;
        data_out_d       = data_out_q;
        bit_count_d      = bit_count_q;
        parity_err_d     = parity_err_q;
        len_err_d        = len_err_q;
        data_valid_d     = 1'b0;
        timeout_err_d    = 1'b0;
        status_changed_d = 1'b0;
        do_stop          = 1'b0;
        pair_changed     = (pair != pair_q);

        if (bus.cfg_wr_en) begin
            cfg_d = bus.cfg_wr_data[CFG_W-2:0];
        end

        case (state_q)
            StIdle: begin
                if (pair != PAIR_IDLE) begin
                    state_d    = StSym;
                    from_gap_d = 1'b0;
                    cnt_d      = '0;
                    ovf_d      = 1'b0;
                    sh_d       = '0;
                    len_snap_d = cfg_q[CFG_LEN_MSB:CFG_LEN_LSB];
                end
            end
            StGap: begin
                if (pair != PAIR_IDLE) begin
                    state_d    = StSym;
                    from_gap_d = 1'b1;
                end
            end
            StSym: begin
                // Classify on the second sample so a one-cycle skew between
                // the lines still reads as the intended symbol.
                case (pair)
                    PAIR_IDLE: begin
                        state_d = from_gap_q ? StGap : StIdle;
                    end
                    PAIR_ONE, PAIR_ZERO: begin
                        if (cnt_q < CNT_W'(MAX_BITS)) begin
                            sh_d  = {sh_q[MAX_BITS-2:0], pair == PAIR_ONE};
                            cnt_d = cnt_q + CNT_W'(1);
                        end else begin
                            ovf_d = 1'b1;
                        end
                        stop_d  = 1'b0;
                        state_d = StRel;
                    end
                    default: begin
                        do_stop = 1'b1;
                        stop_d  = 1'b1;
                        state_d = StRel;
                    end
                endcase
            end
            StRel: begin
                if (pair == PAIR_IDLE) begin
                    state_d = stop_q ? StIdle : StGap;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (do_stop) begin
            data_out_d   = sh_q[MAX_BITS-1:1];
            bit_count_d  = stop_count;
            parity_err_d = ~(^sh_q);
            len_err_d    = ovf_q || (cnt_q < CNT_W'(2))
                           || (stop_count != CNT_W'(len_snap_q));
            data_valid_d = 1'b1;
        end

        if ((state_q == StIdle) || pair_changed) begin
            tmo_d = '0;
        end else begin
            tmo_d = tmo_q + TMO_W'(1);
        end

        // A stop on the same cycle takes priority over the timeout.
        if ((state_q != StIdle) && !pair_changed && !do_stop
            && ((tmo_q + TMO_W'(1)) >= tmo_limit)) begin
            timeout_err_d = 1'b1;
            state_d       = StIdle;
            tmo_d         = '0;
        end

        status_changed_d = ((state_d != StIdle) != (state_q != StIdle));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= StIdle;
            from_gap_q       <= 1'b0;
            stop_q           <= 1'b0;
            ovf_q            <= 1'b0;
            cnt_q            <= '0;
            sh_q             <= '0;
            len_snap_q       <= '0;
            tmo_q            <= '0;
            pair_q           <= PAIR_IDLE;
            cfg_q            <= CFG_RST;
            data_out_q       <= '0;
            bit_count_q      <= '0;
            parity_err_q     <= 1'b0;
            len_err_q        <= 1'b0;
            data_valid_q     <= 1'b0;
            timeout_err_q    <= 1'b0;
            status_changed_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            from_gap_q       <= from_gap_d;
            stop_q           <= stop_d;
            ovf_q            <= ovf_d;
            cnt_q            <= cnt_d;
            sh_q             <= sh_d;
            len_snap_q       <= len_snap_d;
            tmo_q            <= tmo_d;
            pair_q           <= pair_d;
            cfg_q            <= cfg_d;
            data_out_q       <= data_out_d;
            bit_count_q      <= bit_count_d;
            parity_err_q     <= parity_err_d;
            len_err_q        <= len_err_d;
            data_valid_q     <= data_valid_d;
            timeout_err_q    <= timeout_err_d;
            status_changed_q <= status_changed_d;
        end
    end

    assign bus.cfg_rd         = {1'b0, cfg_q};
    assign bus.data_out       = data_out_q;
    assign bus.bit_count      = bit_count_q;
    assign bus.parity_err     = parity_err_q;
    assign bus.len_err        = len_err_q;
    assign bus.data_valid     = data_valid_q;
    assign bus.timeout_err    = timeout_err_q;
    assign bus.busy           = (state_q != StIdle);
    assign bus.status_changed = status_changed_q;

endmodule

// File: tb/tb_sl_word_receiver.sv
`timescale 1ns/1ps
// Bench for sl_word_receiver: directed word/timeout/reset scenarios plus random
// words, all checked against a word-level model and an event scoreboard.
module tb_sl_word_receiver;

    typedef struct packed {
        logic        is_tmo;
        logic [31:0] data;
        logic [5:0]  cnt;
        logic        perr;
        logic        lerr;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sl_word_receiver_if bus ();
    sl_word_receiver dut (.clk(clk), .rst(rst), .bus(bus));

    int          checks = 0;
    int          errors = 0;
    int          sc_cnt = 0;
    logic [9:0]  cfg_exp;
    logic [31:0] last_data = '0;
    exp_t        exp_q[$];
    exp_t        mon_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Word-level reference: bits[i] is the i-th bit sent, n bits in total.
    function automatic exp_t model_word(input logic [63:0] bits, input int n, input int len);
        exp_t e;
        int   kept;
        logic x;
        e    = '0;
        kept = (n > 33) ? 33 : n;
        x    = 1'b0;
        for (int i = 0; i < kept; i++) x ^= bits[i];
        for (int i = 0; i < kept - 1; i++) e.data = {e.data[30:0], bits[i]};
        e.cnt  = (kept == 0) ? 6'd0 : 6'(kept - 1);
        e.perr = ~x;
        e.lerr = (n > 33) || (n < 2) || (int'(e.cnt) != len);
        return e;
    endfunction

    function automatic logic [63:0] make_bits(input logic [63:0] val, input int nd, input logic p);
        logic [63:0] b;
        b = '0;
        for (int i = 0; i < nd; i++) b[i] = val[nd - 1 - i];
        b[nd] = p;
        return b;
    endfunction

    // Scoreboard: every data_valid / timeout_err pulse consumes one expectation.
    always @(negedge clk) begin
        if (!rst) begin
            chk("cfg_rd", 32'(bus.cfg_rd), 32'(cfg_exp));
            if (bus.status_changed) sc_cnt++;
            if (bus.data_valid || bus.timeout_err) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event: data_valid=%0b timeout_err=%0b, expected none at %0t",
                             bus.data_valid, bus.timeout_err, $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (mon_e.is_tmo) begin
                        chk("tmo_pulse", 32'(bus.timeout_err), 32'd1);
                        chk("tmo_no_dv", 32'(bus.data_valid), 32'd0);
                        chk("tmo_busy", 32'(bus.busy), 32'd0);
                    end else begin
                        chk("dv_pulse", 32'(bus.data_valid), 32'd1);
                        chk("dv_no_tmo", 32'(bus.timeout_err), 32'd0);
                        chk("data_out", bus.data_out, mon_e.data);
                        chk("bit_count", 32'(bus.bit_count), 32'(mon_e.cnt));
                        chk("parity_err", 32'(bus.parity_err), 32'(mon_e.perr));
                        chk("len_err", 32'(bus.len_err), 32'(mon_e.lerr));
                        chk("dv_busy", 32'(bus.busy), 32'd1);
                    end
                end
            end
        end
    end

    task automatic cfg_write(input logic [9:0] v);
        @(negedge clk);
        bus.cfg_wr_en   = 1'b1;
        bus.cfg_wr_data = v;
        @(posedge clk);
        cfg_exp = {1'b0, v[8:0]};
        @(negedge clk);
        bus.cfg_wr_en = 1'b0;
    endtask

    task automatic send_bit(input logic v, input int low, input int high);
        @(negedge clk);
        if (v) bus.sl1 = 1'b0;
        else   bus.sl0 = 1'b0;
        repeat (low) @(negedge clk);
        bus.sl0 = 1'b1;
        bus.sl1 = 1'b1;
        repeat (high - 1) @(negedge clk);
    endtask

    task automatic glitch();
        @(negedge clk);
        bus.sl0 = 1'b0;
        @(negedge clk);
        bus.sl0 = 1'b1;
    endtask

    task automatic send_stop(input logic skew, input int low);
        @(negedge clk);
        if ($urandom_range(0, 1) == 1) bus.sl1 = 1'b0;
        else                           bus.sl0 = 1'b0;
        if (skew) @(negedge clk);
        bus.sl0 = 1'b0;
        bus.sl1 = 1'b0;
        repeat (low) @(negedge clk);
        bus.sl0 = 1'b1;
        bus.sl1 = 1'b1;
    endtask

    // Stop driven on both lines at once; data_valid must rise after the 4th edge.
    task automatic stop_latency();
        @(negedge clk);
        bus.sl0 = 1'b0;
        bus.sl1 = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("dv_latency_edge%0d", k), 32'(bus.data_valid), (k == 4) ? 32'd1 : 32'd0);
        end
        @(negedge clk);
        bus.sl0 = 1'b1;
        bus.sl1 = 1'b1;
    endtask

    task automatic send_word(input logic [63:0] bits, input int n, input logic skew,
                             input logic glitches, input logic midcfg, input logic measure);
        exp_t e;
        e = model_word(bits, n, int'(cfg_exp[5:0]));
        exp_q.push_back(e);
        for (int i = 0; i < n; i++) begin
            if (glitches && i > 0 && $urandom_range(0, 3) == 0) glitch();
            send_bit(bits[i], $urandom_range(2, 4), $urandom_range(1, 3));
            if (midcfg && i == 0)
                cfg_write({1'($urandom_range(0, 1)), 3'd0, 6'($urandom_range(8, 32))});
        end
        if (measure) stop_latency();
        else         send_stop(skew, $urandom_range(2, 4));
        repeat (5) @(negedge clk);
        last_data = e.data;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t        e;
        logic [63:0] val;
        logic [63:0] bits;
        logic        got;
        int          len;
        int          n;

        bus.sl0 = 1'b1;
        bus.sl1 = 1'b1;
        bus.cfg_wr_en = 1'b0;
        bus.cfg_wr_data = '0;
        cfg_exp = 10'h008;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_data_out", bus.data_out, 32'd0);
        chk("rst_bit_count", 32'(bus.bit_count), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_flags", {28'd0, bus.parity_err, bus.len_err, bus.data_valid, bus.timeout_err}, 32'd0);
        chk("rst_cfg_rd", 32'(bus.cfg_rd), 32'h008);

        // Pin the model on hand-computed words.
        e = model_word(make_bits(64'hA5, 8, 1'b1), 9, 8);
        chk("model_a5", {e.data[15:0], 2'b00, e.cnt, 6'd0, e.perr, e.lerr}, {16'h00A5, 2'b00, 6'd8, 6'd0, 1'b0, 1'b0});
        e = model_word(make_bits(64'hDEADBEEF, 32, 1'b0), 33, 32);
        chk("model_dead_data", e.data, 32'hDEADBEEF);
        chk("model_dead_perr", 32'(e.perr), 32'd1);
        e = model_word(make_bits(64'h00F0_0FF0_F0F0, 39, 1'b1), 40, 16);
        chk("model_ovf", {25'd0, e.cnt, e.lerr}, {25'd0, 6'd32, 1'b1});

        // Length 8, 0xA5 with good parity, latency measured on the stop.
        send_word(make_bits(64'hA5, 8, 1'b1), 9, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("a5_data_out", bus.data_out, 32'hA5);
        chk("a5_bit_count", 32'(bus.bit_count), 32'd8);
        chk("a5_errs", {30'd0, bus.parity_err, bus.len_err}, 32'd0);

        // Length 32, 0xDEADBEEF with wrong parity.
        cfg_write(10'h020);
        send_word(make_bits(64'hDEADBEEF, 32, 1'b0), 33, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("dead_data_out", bus.data_out, 32'hDEADBEEF);
        chk("dead_perr", 32'(bus.parity_err), 32'd1);

        // Length 16: a short word then an overflowing one.
        cfg_write(10'h010);
        send_word(make_bits(64'h5A5, 11, 1'b0), 12, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("short_len_err", 32'(bus.len_err), 32'd1);
        send_word(make_bits(64'h00C3_A5F0_0FF0, 39, 1'b1), 40, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("ovf_len_err", 32'(bus.len_err), 32'd1);
        chk("ovf_bit_count", 32'(bus.bit_count), 32'd32);

        // Mode 2: sl0 held low, timeout 64 clocks after the last decoded change.
        // The line stays low past the timeout, so a second word opens and times
        // out in the gap after release.
        cfg_write(10'b0_010_001000);
        e = '0;
        e.is_tmo = 1'b1;
        exp_q.push_back(e);
        exp_q.push_back(e);
        @(negedge clk);
        bus.sl0 = 1'b0;
        for (int k = 1; k <= 67; k++) begin
            @(posedge clk);
            #1;
            if (k == 66) chk("tmo_not_early", 32'(bus.timeout_err), 32'd0);
        end
        chk("tmo_at_64", 32'(bus.timeout_err), 32'd1);
        chk("tmo_busy_low", 32'(bus.busy), 32'd0);
        chk("tmo_no_dv_direct", 32'(bus.data_valid), 32'd0);
        chk("tmo_data_kept", bus.data_out, last_data);
        repeat (33) @(negedge clk);
        bus.sl0 = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 150 && !got; k++) begin
            @(posedge clk);
            #1;
            if (bus.timeout_err) got = 1'b1;
        end
        chk("second_tmo_seen", 32'(got), 32'd1);
        repeat (3) @(negedge clk);

        // Length 8 with skewed stop and a one-cycle glitch between every bit.
        cfg_write(10'h008);
        bits = make_bits(64'h5A, 8, 1'b1);
        exp_q.push_back(model_word(bits, 9, 8));
        for (int i = 0; i < 9; i++) begin
            if (i > 0) glitch();
            send_bit(bits[i], 2, 1);
        end
        send_stop(1'b1, 2);
        repeat (5) @(negedge clk);
        chk("glitch_data_out", bus.data_out, 32'h5A);
        chk("glitch_bit_count", 32'(bus.bit_count), 32'd8);

        // Reset mid-word, then a clean 0x3C.
        cfg_write(10'h014);
        send_bit(1'b1, 2, 1);
        send_bit(1'b0, 2, 1);
        send_bit(1'b1, 2, 1);
        @(negedge clk);
        rst = 1'b1;
        cfg_exp = 10'h008;
        @(posedge clk);
        #1;
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_status", 32'(bus.status_changed), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_status2", 32'(bus.status_changed), 32'd0);
        chk("midrst_outs", {bus.data_out[25:0], bus.bit_count}, 32'd0);
        chk("midrst_cfg", 32'(bus.cfg_rd), 32'h008);
        sc_cnt = 0;
        send_word(make_bits(64'h3C, 8, 1'b1), 9, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("3c_data_out", bus.data_out, 32'h3C);
        chk("3c_errs", {30'd0, bus.parity_err, bus.len_err}, 32'd0);
        chk("3c_status_pulses", 32'(sc_cnt), 32'd2);

        // Random words: length, size, parity, skew, glitches, mid-word config.
        for (int w = 0; w < 30; w++) begin
            len = $urandom_range(8, 32);
            cfg_write({1'($urandom_range(0, 1)), 3'd0, 6'(len)});
            n   = ($urandom_range(0, 1) == 1) ? len + 1 : $urandom_range(2, 36);
            val = {$urandom, $urandom};
            bits = make_bits(val, n - 1, 1'($urandom_range(0, 1)));
            send_word(bits, n, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 3) == 0), 1'b0);
        end

        for (int k = 0; k < 200 && exp_q.size() != 0; k++) @(negedge clk);
        chk("events_pending", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
